// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction fetch stage: PC, imem request, IF/ID register.
// Optional J/JAL pre-decode at fetch is enabled by defining FETCH_EARLY_JUMP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_00A0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic        advance;
    logic        early_jump;
    logic        id_valid_q;
    logic [31:0] id_instr_q, id_pc_q, id_pc_plus4_q;

    assign pc_plus4 = pc_q + 32'd4;
    assign advance  = !id_valid_q || id_ready;

`ifdef FETCH_EARLY_JUMP_EN
    // J is opcode 000010, JAL is 000011: they differ only in bit 26.
    assign early_jump = (imem_instr[31:27] == 5'b00001);
`else
    assign early_jump = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (advance) begin
            if (early_jump) begin
                pc_d = {pc_plus4[31:28], imem_instr[25:0], 2'b00};
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (redirect_valid) begin
                id_valid_q <= 1'b0;
            end else if (advance) begin
                id_valid_q    <= 1'b1;
                id_instr_q    <= imem_instr;
                id_pc_q       <= pc_q;
                id_pc_plus4_q <= pc_plus4;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;

endmodule
